// File: rtl/bin2bcd_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter.
package bin2bcd_pkg;

    localparam int unsigned WIDTH_DEF  = 16;
    localparam int unsigned DIGITS_DEF = 5;

    // Code driven on a suppressed leading-zero digit; the 7-segment decoder shows it as all-off.
    localparam logic [3:0] BCD_BLANK = 4'hF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

endpackage : bin2bcd_pkg

// File: rtl/bcd_add3.sv
// Double-dabble digit correction: a BCD digit of 5 or more gets 3 added before the next shift.
module bcd_add3 (
    input  logic [3:0] din,
    output logic [3:0] dout_c
);

    // Correct the digit so the following left shift carries cleanly into the next decade.
    always_comb begin
        dout_c = din;
        if (din >= 4'd5) begin
            dout_c = din + 4'd3;
        end
    end

endmodule : bcd_add3

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3), one input bit per clock.
// Optional leading-zero blanking of the output digits is enabled with macro BIN2BCD_BLANK_EN.
module bin2bcd_seq
    import bin2bcd_pkg::*;
#(
    parameter int unsigned WIDTH  = WIDTH_DEF,
    parameter int unsigned DIGITS = DIGITS_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [WIDTH-1:0]    bin,
    output logic                busy,
    output logic                done,
    output logic [4*DIGITS-1:0] bcd
);

    localparam int unsigned      BCD_W    = 4 * DIGITS;
    localparam int unsigned      CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_e             state_q,   state_d;
    logic [BCD_W-1:0]   scratch_q, scratch_d;
    logic [WIDTH-1:0]   sreg_q,    sreg_d;
    logic [CNT_W-1:0]   cnt_q,     cnt_d;
    logic               busy_q,    busy_d;
    logic               done_q,    done_d;
    logic [BCD_W-1:0]   bcd_q,     bcd_d;

    logic [BCD_W-1:0]   adj;
    logic [BCD_W-1:0]   scratch_next;
    logic [WIDTH-1:0]   sreg_next;
    logic [BCD_W-1:0]   bcd_fmt;

    // One add-3 corrector per decimal digit of the scratch register.
    for (genvar g = 0; g < DIGITS; g++) begin : g_add3
        bcd_add3 u_add3 (
            .din    (scratch_q[4*g +: 4]),
            .dout_c (adj[4*g +: 4])
        );
    end

    // Shift {corrected scratch, shift register} left by one; the dropped MSB is always zero when DIGITS is sized correctly.
    always_comb begin
        scratch_next = BCD_W'({adj, sreg_q[WIDTH-1]});
        sreg_next    = WIDTH'({sreg_q, 1'b0});
    end

`ifdef BIN2BCD_BLANK_EN
    logic lead_zero;

    // Replace each leading-zero digit above the units digit with the blank code.
    always_comb begin
        bcd_fmt   = scratch_next;
        lead_zero = 1'b1;
        for (int i = int'(DIGITS) - 1; i >= 1; i--) begin
            if (lead_zero && (scratch_next[4*i +: 4] == 4'd0)) begin
                bcd_fmt[4*i +: 4] = BCD_BLANK;
            end else begin
                lead_zero = 1'b0;
            end
        end
    end
`else
    // Plain BCD result, leading zeros kept.
    always_comb begin
        bcd_fmt = scratch_next;
    end
`endif

    // Next-state and datapath control for the IDLE -> SHIFT -> DONE sequence.
    always_comb begin
        state_d   = state_q;
        scratch_d = scratch_q;
        sreg_d    = sreg_q;
        cnt_d     = cnt_q;
        bcd_d     = bcd_q;
        busy_d    = 1'b0;
        done_d    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    sreg_d    = bin;
                    scratch_d = '0;
                    cnt_d     = '0;
                    busy_d    = 1'b1;
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                scratch_d = scratch_next;
                sreg_d    = sreg_next;
                cnt_d     = cnt_q + CNT_W'(1);
                busy_d    = 1'b1;
                if (cnt_q == CNT_LAST) begin
                    // Result is published on entry so bcd and done line up in the DONE cycle.
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    bcd_d   = bcd_fmt;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset that aborts any conversion.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            scratch_q <= '0;
            sreg_q    <= '0;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            bcd_q     <= '0;
        end else begin
            state_q   <= state_d;
            scratch_q <= scratch_d;
            sreg_q    <= sreg_d;
            cnt_q     <= cnt_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            bcd_q     <= bcd_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign bcd  = bcd_q;

endmodule : bin2bcd_seq

// File: tb/tb_bin2bcd_seq.sv
// Scoreboard bench for bin2bcd_seq: driver predicts accepted conversions, monitor checks every cycle.
module tb_bin2bcd_seq;

    localparam int WIDTH   = 16;
    localparam int DIGITS  = 5;
    localparam int BCD_W   = 4 * DIGITS;
    localparam int LAT     = WIDTH + 1;
    localparam int SPACING = WIDTH + 2;

    logic               clk = 1'b0;
    logic               rst;
    logic               start;
    logic [WIDTH-1:0]   bin;
    logic               busy;
    logic               done;
    logic [BCD_W-1:0]   bcd;

    bin2bcd_seq #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .bcd   (bcd)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [BCD_W-1:0] bcd;
        int               cyc;
    } exp_t;

    exp_t             sb[$];
    int               free_cyc = 0;
    int               last_rst = 0;
    int               checks   = 0;
    int               errors   = 0;
    logic [BCD_W-1:0] hold     = '0;

    // Decimal digits by repeated division, then optional leading-zero blanking.
    function automatic logic [BCD_W-1:0] ref_bcd(input logic [WIDTH-1:0] v);
        logic [BCD_W-1:0] r;
        int unsigned      x;
`ifdef BIN2BCD_BLANK_EN
        bit               lead;
`endif
        r = '0;
        x = 32'(v);
        for (int i = 0; i < DIGITS; i++) begin
            r[i*4 +: 4] = 4'(x % 10);
            x = x / 10;
        end
`ifdef BIN2BCD_BLANK_EN
        lead = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            if (lead && r[i*4 +: 4] == 4'd0) r[i*4 +: 4] = 4'hF;
            else lead = 1'b0;
        end
`endif
        return r;
    endfunction

    task automatic check(input string name, input int m, input logic [BCD_W-1:0] act,
                         input logic [BCD_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors < 30)
                $display("FAIL %s cycle %0d: got %0h expected %0h", name, m, act, exp);
        end
    endtask

    // Drive one cycle of inputs and record what the DUT must do with them.
    task automatic drive(input bit s, input logic [WIDTH-1:0] b, input bit r);
        @(negedge clk);
        #1;
        start = s;
        bin   = b;
        rst   = r;
        if (r) begin
            for (int i = sb.size() - 1; i >= 0; i--)
                if (sb[i].cyc > cyc) sb.delete(i);
            free_cyc = cyc + 1;
            last_rst = cyc;
        end else if (s && cyc >= free_cyc) begin
            sb.push_back('{ref_bcd(b), cyc + LAT});
            free_cyc = cyc + SPACING;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, WIDTH'($urandom), 1'b0);
    endtask

    // Monitor: compares done, busy and bcd each cycle against the scoreboard.
    task automatic monitor_cycle(input int m);
        bit exp_done = 1'b0;
        bit exp_busy = 1'b0;
        if (m == last_rst + 1) hold = '0;
        while (sb.size() > 0 && sb[0].cyc < m) begin
            checks++;
            errors++;
            $display("FAIL missed_done cycle %0d: no done seen, expected at cycle %0d", m, sb[0].cyc);
            void'(sb.pop_front());
        end
        if (sb.size() > 0 && sb[0].cyc == m) begin
            exp_done = 1'b1;
            hold     = sb[0].bcd;
            void'(sb.pop_front());
        end else if (sb.size() > 0 && m >= sb[0].cyc - WIDTH) begin
            exp_busy = 1'b1;
        end
        check("done", m, BCD_W'(done), BCD_W'(exp_done));
        check("busy", m, BCD_W'(busy), BCD_W'(exp_busy));
        check("bcd",  m, bcd, hold);
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (cyc >= 1) monitor_cycle(cyc);
        end
    end

    logic [WIDTH-1:0] held_vals [4] = '{16'd9, 16'd10, 16'd99, 16'd100};
    logic [WIDTH-1:0] corners   [6] = '{16'd0, 16'hFFFF, 16'd9, 16'd10, 16'd9999, 16'd10000};

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        bin   = '0;
        drive(1'b0, '0, 1'b1);
        drive(1'b0, '0, 1'b1);

        // Basic conversion and boundary values.
        drive(1'b1, 16'd1234, 1'b0);
        idle(20);
        drive(1'b1, 16'd65535, 1'b0);
        idle(18);
        drive(1'b1, 16'd0, 1'b0);
        idle(18);

        // Start requests during SHIFT and DONE are ignored.
        drive(1'b1, 16'd42, 1'b0);
        repeat (LAT) drive(1'b1, 16'd999, 1'b0);
        idle(3);

        // Reset mid-conversion aborts with no done, then a fresh conversion.
        drive(1'b1, 16'd500, 1'b0);
        idle(7);
        drive(1'b0, '0, 1'b1);
        drive(1'b1, 16'd7, 1'b0);
        idle(20);

        // Start held high: back-to-back conversions; bin scrambled after each acceptance.
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, held_vals[k], 1'b0);
            repeat (SPACING - 1) drive(1'b1, WIDTH'($urandom), 1'b0);
        end
        idle(20);

        // Randomized traffic with occasional resets.
        repeat (1500) begin
            bit               s, r;
            logic [WIDTH-1:0] b;
            r = ($urandom_range(0, 149) == 0);
            s = ($urandom_range(0, 2) == 0);
            b = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 5)] : WIDTH'($urandom);
            drive(s, b, r);
        end
        idle(SPACING + 4);

        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d conversions outstanding, expected 0", sb.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_bin2bcd_seq
